// File: rtl/omem_stream.sv
// Output memory with registered random read and a valid/ready burst drain engine.
// DEPTH banks of DW bits. A drain streams COUNT consecutive banks, wrapping at DEPTH.
// Optional feature macro: OMEM_PARITY_EN adds per-bank even parity and the par_err output.
module omem_stream #(
   parameter int DW    = 9,
   parameter int DEPTH = 60,
   parameter int AW    = 6
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          wr,
   input  logic [AW-1:0] wr_bank,
   input  logic [DW-1:0] wr_data,
   input  logic          rd,
   input  logic [AW-1:0] rd_bank,
   output logic [DW-1:0] rd_data,
   input  logic          start,
   input  logic [AW-1:0] start_bank,
   input  logic [AW:0]   count,
   input  logic          abort,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last
`ifdef OMEM_PARITY_EN
   ,
   output logic          par_err
`endif
);

`ifdef OMEM_PARITY_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = DW;
`endif
   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_BANK = AW'(DEPTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [MW-1:0] mem [DEPTH];
   logic [AW-1:0] ptr_q;
   logic [AW:0]   rem_q;
   logic [MW-1:0] word_p1;
   logic          last_p1, vld_p1;
   logic [MW-1:0] head_p2, tail_p2;
   logic          head_last_p2, tail_last_p2;
   logic [1:0]    cnt_p2;
   logic [2:0]    occ;
   logic          accept, issue, issue_last, pop, space;
   logic [AW-1:0] issue_bank;
   logic          wr_ok, rd_ok, start_ok;

   // Stored word: payload, plus even parity bit when enabled.
   function automatic logic [MW-1:0] encode(input logic [DW-1:0] d);
`ifdef OMEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // Bank pointer increment, wrapping DEPTH-1 back to 0.
   function automatic logic [AW-1:0] next_bank(input logic [AW-1:0] b);
      return (b == LAST_BANK) ? '0 : b + AW'(1);
   endfunction

   assign wr_ok    = {1'b0, wr_bank} < DEPTH_W;
   assign rd_ok    = {1'b0, rd_bank} < DEPTH_W;
   assign start_ok = {1'b0, start_bank} < DEPTH_W;

   assign busy      = (state_q == RUN);
   assign out_valid = (cnt_p2 != 2'd0);
   assign out_data  = head_p2[DW-1:0];
   assign out_last  = out_valid && head_last_p2;

   // Next-state and read-issue decisions; reads in flight plus skid entries never exceed two.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      issue_bank = ptr_q;
      pop        = out_valid && out_ready;
      occ        = {1'b0, cnt_p2} + {2'b00, vld_p1};
      space      = occ < (pop ? 3'd3 : 3'd2);
      case (state_q)
         IDLE: begin
            if (start && !abort && (count != '0) && start_ok) begin
               state_d    = RUN;
               accept     = 1'b1;
               issue      = 1'b1;
               issue_bank = start_bank;
               issue_last = (count == (AW+1)'(1));
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (pop && head_last_p2) state_d = IDLE;
               if ((rem_q != '0) && space) begin
                  issue      = 1'b1;
                  issue_last = (rem_q == (AW+1)'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Memory write port; out-of-range banks are dropped.
   always_ff @(posedge clock) begin
      if (wr && wr_ok) mem[wr_bank] <= encode(wr_data);
   end

   // Drain pointer, remaining-read count and read-valid tracking.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q   <= '0;
         rem_q   <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         if (accept) begin
            ptr_q <= next_bank(start_bank);
            rem_q <= count - (AW+1)'(1);
         end else if (issue) begin
            ptr_q <= next_bank(ptr_q);
            rem_q <= rem_q - (AW+1)'(1);
         end
         vld_p1 <= issue;
         if (issue) last_p1 <= issue_last;
      end
   end

   // ---- stage p1: RAM read data ----
   // Drain read of the RAM; a same-edge write leaves the old word here.
   always_ff @(posedge clock) begin
      if (issue) word_p1 <= mem[issue_bank];
   end

   // ---- stage p2: two-entry skid buffer, head drives the stream ----
   // Skid buffer: head is the presented beat, tail absorbs the read in flight during a stall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_p2       <= 2'd0;
         head_p2      <= '0;
         head_last_p2 <= 1'b0;
         tail_p2      <= '0;
         tail_last_p2 <= 1'b0;
      end else if ((state_q == RUN) && abort) begin
         cnt_p2 <= 2'd0;
      end else begin
         case (cnt_p2)
            2'd0: begin
               if (vld_p1) begin
                  head_p2      <= word_p1;
                  head_last_p2 <= last_p1;
                  cnt_p2       <= 2'd1;
               end
            end
            2'd1: begin
               if (vld_p1 && pop) begin
                  head_p2      <= word_p1;
                  head_last_p2 <= last_p1;
               end else if (vld_p1) begin
                  tail_p2      <= word_p1;
                  tail_last_p2 <= last_p1;
                  cnt_p2       <= 2'd2;
               end else if (pop) begin
                  cnt_p2 <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  head_p2      <= tail_p2;
                  head_last_p2 <= tail_last_p2;
                  if (vld_p1) begin
                     tail_p2      <= word_p1;
                     tail_last_p2 <= last_p1;
                  end else begin
                     cnt_p2 <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   // Random read port, honoured only while idle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                   rd_data <= '0;
      else if (rd && state_q == IDLE) rd_data <= rd_ok ? mem[rd_bank][DW-1:0] : '0;
   end

`ifdef OMEM_PARITY_EN
   logic rd_perr_q;

   // Parity flag for the random read, lined up with the rd_data update.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_perr_q <= 1'b0;
      else          rd_perr_q <= rd && (state_q == IDLE) && rd_ok && (^mem[rd_bank]);
   end

   assign par_err = rd_perr_q | (pop && (^head_p2));
`endif

endmodule

// File: tb/tb_omem_stream.sv
// Scoreboard bench for omem_stream: expected beats are queued when a drain is started
// and compared against the stream as it is presented.
module tb_omem_stream;
   localparam int DW    = 9;
   localparam int DEPTH = 60;
   localparam int AW    = 6;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          wr, rd, start, abort, out_ready;
   logic [AW-1:0] wr_bank, rd_bank, start_bank;
   logic [DW-1:0] wr_data;
   logic [AW:0]   count;
   logic [DW-1:0] rd_data, out_data;
   logic          busy, out_valid, out_last;
`ifdef OMEM_PARITY_EN
   logic          par_err;
`endif

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] model [DEPTH];
   logic          tog = 1'b0;
   int            n;

   omem_stream #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr         (wr),
      .wr_bank    (wr_bank),
      .wr_data    (wr_data),
      .rd         (rd),
      .rd_bank    (rd_bank),
      .rd_data    (rd_data),
      .start      (start),
      .start_bank (start_bank),
      .count      (count),
      .abort      (abort),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
`ifdef OMEM_PARITY_EN
      ,
      .par_err    (par_err)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      out_ready = tog ? ~out_ready : 1'b1;
   endtask

   task automatic write_bank(input int b, input int d);
      wr      = 1'b1;
      wr_bank = AW'(b);
      wr_data = DW'(d);
      tick();
      wr      = 1'b0;
   endtask

   task automatic push_drain(input int sb, input int cnt);
      for (int k = 0; k < cnt; k++)
         exp_q.push_back({(k == cnt - 1), model[(sb + k) % DEPTH]});
   endtask

   task automatic start_drain(input int sb, input int cnt);
      start      = 1'b1;
      start_bank = AW'(sb);
      count      = (AW+1)'(cnt);
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (busy && cyc < budget) begin
         tick();
         cyc++;
      end
      check_eq(tag, 32'(busy), 0);
   endtask

   // Stream monitor: every presented beat must match the head of the scoreboard.
   always @(negedge clock) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_beat", 32'(exp_q.size()), 1);
         end else begin
            check_eq("beat_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
            check_eq("beat_last", 32'(out_last), 32'(exp_q[0][DW]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; wr = 1'b0; rd = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      wr_bank = '0; rd_bank = '0; start_bank = '0; wr_data = '0; count = '0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_rd_data", 32'(rd_data), 0);
      check_eq("rst_out_data", 32'(out_data), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_out_last", 32'(out_last), 0);
      check_eq("rst_busy", 32'(busy), 0);
`ifdef OMEM_PARITY_EN
      check_eq("rst_par_err", 32'(par_err), 0);
`endif
      reset_n = 1'b1;
      tick();

      // write then random read
      write_bank(7, 'h1A5);
      rd = 1'b1; rd_bank = 6'd7;
      tick();
      rd = 1'b0;
      check_eq("rd_bank7", 32'(rd_data), 'h1A5);
      rd = 1'b1; rd_bank = 6'd60;
      tick();
      rd = 1'b0;
      check_eq("rd_oob", 32'(rd_data), 0);

      for (int i = 0; i < DEPTH; i++) begin
         write_bank(i, i);
         model[i] = DW'(i);
      end

      // wrapping drain 58,59,0,1
      push_drain(58, 4);
      start_drain(58, 4);
      check_eq("t2_busy_c1", 32'(busy), 1);
      check_eq("t2_vld_c1", 32'(out_valid), 0);
      rd = 1'b1; rd_bank = 6'd7;
      tick();
      rd = 1'b0;
      check_eq("t2_vld_c2", 32'(out_valid), 1);
      check_eq("t2_rd_ignored", 32'(rd_data), 0);
      wait_idle("t2_idle", 20, n);
      check_eq("t2_done_cyc", n, 4);
      check_eq("t2_sb_empty", exp_q.size(), 0);

      // full-depth drain with out_ready toggling
      tog = 1'b1;
      push_drain(0, 60);
      start_drain(0, 60);
      wait_idle("t3_idle", 400, n);
      tog = 1'b0;
      tick();
      check_eq("t3_sb_empty", exp_q.size(), 0);

      // writes racing the drain: bank 10 in the start cycle keeps old data, bank 20 ahead of ptr is new
      model[20] = DW'('h0FF);
      push_drain(10, 20);
      model[10] = DW'('h0FF);
      wr = 1'b1; wr_bank = 6'd10; wr_data = 9'h0FF;
      start = 1'b1; start_bank = 6'd10; count = 7'd20;
      tick();
      start = 1'b0; wr_bank = 6'd20;
      tick();
      wr = 1'b0;
      wait_idle("t4_idle", 100, n);
      check_eq("t4_sb_empty", exp_q.size(), 0);
      rd = 1'b1; rd_bank = 6'd10;
      tick();
      rd = 1'b0;
      check_eq("t4_rd_bank10", 32'(rd_data), 'h0FF);

      // abort after three beats
      push_drain(0, 10);
      start_drain(0, 10);
      tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t5_abort_vld", 32'(out_valid), 0);
      check_eq("t5_abort_busy", 32'(busy), 0);
      check_eq("t5_beats_taken", exp_q.size(), 7);
      exp_q.delete();
      tick();
      check_eq("t5_quiet", 32'(out_valid), 0);
      push_drain(5, 3);
      start_drain(5, 3);
      wait_idle("t5_restart_idle", 30, n);
      check_eq("t5_sb_empty", exp_q.size(), 0);
      start_drain(5, 0);
      check_eq("t5_cnt0_busy", 32'(busy), 0);
      tick();
      check_eq("t5_cnt0_vld", 32'(out_valid), 0);
      abort = 1'b1;
      start_drain(5, 3);
      abort = 1'b0;
      check_eq("t5_abort_prio", 32'(busy), 0);
      start_drain(60, 3);
      check_eq("t5_bad_bank", 32'(busy), 0);

      // asynchronous reset in the middle of a drain
      push_drain(0, 20);
      start_drain(0, 20);
      tick();
      check_eq("t6_pre_vld", 32'(out_valid), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("t6_vld", 32'(out_valid), 0);
      check_eq("t6_data", 32'(out_data), 0);
      check_eq("t6_last", 32'(out_last), 0);
      check_eq("t6_busy", 32'(busy), 0);
      check_eq("t6_rd_data", 32'(rd_data), 0);
      exp_q.delete();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) write_bank(i, 'h100 + i);
      for (int i = 0; i < 4; i++) model[i] = DW'('h100 + i);
      push_drain(0, 4);
      start_drain(0, 4);
      wait_idle("t6_after_idle", 30, n);
      check_eq("t6_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
